cvs_out_sequencer: RTL and testbench

CVS_OUT_SEQUENCER -- requirements
Module: cvs_out_sequencer

---
 rtl/cvs_out_sequencer_pkg.sv | 14 +
 rtl/cvs_out_sequencer_if.sv | 29 ++
 rtl/cvs_out_sequencer_next_index.sv | 28 ++
 rtl/cvs_out_sequencer.sv | 138 +++++++++++++
 tb/tb_cvs_out_sequencer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/cvs_out_sequencer_pkg.sv
// Shared defaults and FSM state type for the output sequencer.
package cvs_pkg;

  localparam int unsigned NUM_OUT_DEF = 5;
  localparam int unsigned DWELL_W_DEF = 16;
  localparam int unsigned IDX_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cvs_state_t;

endpackage

// File: rtl/cvs_out_sequencer_if.sv
// Request/status bundle between a sequencer controller and cvs_out_sequencer.
interface cvs_out_sequencer_if
  import cvs_pkg::*;
#(
  parameter int unsigned NUM_OUT = NUM_OUT_DEF,
  parameter int unsigned DWELL_W = DWELL_W_DEF
);

  logic               start;
  logic               stop;
  logic [DWELL_W-1:0] dwell;
  logic [NUM_OUT-1:0] mask;
  logic [NUM_OUT-1:0] out;
  logic [IDX_W-1:0]   step_idx;
  logic               busy;
  logic               done;
  logic               aborted;

  modport master (
    output start, stop, dwell, mask,
    input  out, step_idx, busy, done, aborted
  );

  modport slave (
    input  start, stop, dwell, mask,
    output out, step_idx, busy, done, aborted
  );

endinterface

// File: rtl/cvs_out_sequencer_next_index.sv
// Finds the lowest set mask bit above (or, when inclusive, at) a base index.
module cvs_next_index
  import cvs_pkg::*;
#(
  parameter int unsigned NUM_OUT = NUM_OUT_DEF
) (
  input  logic [NUM_OUT-1:0] mask,
  input  logic [IDX_W-1:0]   base,
  input  logic               inclusive,
  output logic [IDX_W-1:0]   idx,
  output logic               none
);

  int unsigned base_i;

  always_comb begin
    idx    = '0;
    none   = 1'b1;
    base_i = 32'(base);
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (none && mask[i] && ((i > base_i) || (inclusive && (i == base_i)))) begin
        idx  = IDX_W'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cvs_out_sequencer.sv
// Steps a one-hot output across enabled mask bits, holding each for dwell+1 cycles.
module cvs_out_sequencer
  import cvs_pkg::*;
#(
  parameter int unsigned NUM_OUT = NUM_OUT_DEF,
  parameter int unsigned DWELL_W = DWELL_W_DEF
) (
  input logic               clock,
  input logic               reset,
  cvs_out_sequencer_if.slave bus
);

  cvs_state_t         state_q, state_d;
  logic [NUM_OUT-1:0] out_q, out_d;
  logic [NUM_OUT-1:0] mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               abort_q, abort_d;

  logic [IDX_W-1:0]   first_idx, next_idx;
  logic               first_none, next_none;

  // Start searches the live mask from bit 0; stepping searches the latched mask.
  cvs_next_index #(.NUM_OUT(NUM_OUT)) u_first (
    .mask      (bus.mask),
    .base      ('0),
    .inclusive (1'b1),
    .idx       (first_idx),
    .none      (first_none)
  );

  cvs_next_index #(.NUM_OUT(NUM_OUT)) u_next (
    .mask      (mask_q),
    .base      (idx_q),
    .inclusive (1'b0),
    .idx       (next_idx),
    .none      (next_none)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        out_d  = '0;
        busy_d = 1'b0;
        if (bus.start && !bus.stop) begin
          mask_d  = bus.mask;
          dwell_d = bus.dwell;
          busy_d  = 1'b1;
          if (first_none) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
            out_d   = NUM_OUT'(1) << first_idx;
            idx_d   = first_idx;
            cnt_d   = bus.dwell;
          end
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
          out_d   = '0;
          busy_d  = 1'b0;
          abort_d = 1'b1;
        end else if (cnt_q == '0) begin
          if (next_none) begin
            state_d = ST_DONE;
            out_d   = '0;
            done_d  = 1'b1;
          end else begin
            out_d = NUM_OUT'(1) << next_idx;
            idx_d = next_idx;
            cnt_d = dwell_q;
          end
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        out_d   = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        out_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      mask_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign bus.out      = out_q;
  assign bus.step_idx = idx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.aborted  = abort_q;

endmodule

// File: tb/tb_cvs_out_sequencer.sv
// Directed self-checking bench for cvs_out_sequencer with hand-computed expectations.
module tb_cvs_out_sequencer;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  logic [4:0] e_out;
  logic [2:0] e_idx;

  cvs_out_sequencer_if #(.NUM_OUT(5), .DWELL_W(16)) bus ();

  cvs_out_sequencer #(.NUM_OUT(5), .DWELL_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] o, input logic [2:0] idx,
                         input logic b, input logic d, input logic a);
    chk($sformatf("%s.out", tag),      32'(bus.out),      32'(o));
    chk($sformatf("%s.step_idx", tag), 32'(bus.step_idx), 32'(idx));
    chk($sformatf("%s.busy", tag),     32'(bus.busy),     32'(b));
    chk($sformatf("%s.done", tag),     32'(bus.done),     32'(d));
    chk($sformatf("%s.aborted", tag),  32'(bus.aborted),  32'(a));
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.dwell = '0;
    bus.mask  = '0;
    tick();
    tick();
    chk_all("reset", 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();

    // mask 10101, dwell 2: three cycles on each of bits 0, 2, 4, done at +10
    bus.mask  = 5'b10101;
    bus.dwell = 16'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.mask  = 5'b01010;
    bus.dwell = 16'd7;
    for (int c = 1; c <= 9; c++) begin
      e_out = (c <= 3) ? 5'b00001 : (c <= 6) ? 5'b00100 : 5'b10000;
      e_idx = (c <= 3) ? 3'd0 : (c <= 6) ? 3'd2 : 3'd4;
      chk_all($sformatf("seq10101.c%0d", c), e_out, e_idx, 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk_all("seq10101.done", 5'b00000, 3'd4, 1'b1, 1'b1, 1'b0);
    tick();
    chk_all("seq10101.idle", 5'b00000, 3'd4, 1'b0, 1'b0, 1'b0);

    // empty mask goes straight to DONE
    bus.mask  = 5'b00000;
    bus.dwell = 16'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_all("mask0.done", 5'b00000, 3'd4, 1'b1, 1'b1, 1'b0);
    tick();
    chk_all("mask0.idle", 5'b00000, 3'd4, 1'b0, 1'b0, 1'b0);

    // mask 11111, dwell 0: single-cycle walk
    bus.mask  = 5'b11111;
    bus.dwell = 16'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      e_out = 5'b00001 << (c - 1);
      e_idx = 3'(c - 1);
      chk_all($sformatf("walk.c%0d", c), e_out, e_idx, 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk_all("walk.done", 5'b00000, 3'd4, 1'b1, 1'b1, 1'b0);
    tick();

    // stop sampled at cycle+4 aborts
    bus.mask  = 5'b00011;
    bus.dwell = 16'd9;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_all("abort.c1", 5'b00001, 3'd0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk_all("abort.c4", 5'b00001, 3'd0, 1'b1, 1'b0, 1'b0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk_all("abort.pulse", 5'b00000, 3'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_all("abort.after", 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("abort.idle", 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);

    // start together with stop in IDLE is ignored
    bus.mask  = 5'b00001;
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk_all("startstop", 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);

    // start re-pulsed during RUN is ignored
    bus.mask  = 5'b00110;
    bus.dwell = 16'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      e_out = (c <= 2) ? 5'b00010 : 5'b00100;
      e_idx = (c <= 2) ? 3'd1 : 3'd2;
      chk_all($sformatf("restart.c%0d", c), e_out, e_idx, 1'b1, 1'b0, 1'b0);
      if (c == 1 || c == 3) begin
        bus.mask  = 5'b11001;
        bus.dwell = 16'd0;
        bus.start = 1'b1;
      end
      tick();
      bus.start = 1'b0;
    end
    chk_all("restart.done", 5'b00000, 3'd2, 1'b1, 1'b1, 1'b0);
    tick();

    // asynchronous reset mid-RUN
    bus.mask  = 5'b11111;
    bus.dwell = 16'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk_all("rst.pre", 5'b00001, 3'd0, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_all("rst.async", 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    chk_all("rst.release1", 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("rst.release2", 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    bus.mask  = 5'b01000;
    bus.dwell = 16'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_all("rst.new.c1", 5'b01000, 3'd3, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("rst.new.done", 5'b00000, 3'd3, 1'b1, 1'b1, 1'b0);
    tick();
    chk_all("rst.new.idle", 5'b00000, 3'd3, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
